// File: rtl/iterative_shifter.sv
// Multi-cycle shifter/rotator: moves at most STEP bit positions per BUSY cycle.
// Define ITERATIVE_SHIFTER_FLAGS_EN to build the carry_out/zero flag registers.
module iterative_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [2:0]               shift_type,
    input  logic [$clog2(WIDTH)-1:0] shift_amnt,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         out_data,
    output logic                     carry_out,
    output logic                     zero
);

    localparam int AW = $clog2(WIDTH);
    // AW+1 bits so that STEP==WIDTH and WIDTH itself are representable
    localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);
    localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);

    localparam logic [2:0] T_SLL = 3'b000;
    localparam logic [2:0] T_SLA = 3'b001;
    localparam logic [2:0] T_SRL = 3'b010;
    localparam logic [2:0] T_SRA = 3'b011;
    localparam logic [2:0] T_ROL = 3'b100;
    localparam logic [2:0] T_ROR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [2:0]       type_q, type_d;
    logic [AW:0]      step_s;
    logic [WIDTH-1:0] step_out;

    assign step_s = ({1'b0, rem_q} > STEP_W) ? STEP_W : {1'b0, rem_q};

    always_comb begin
        step_out = out_q;
        case (type_q)
            T_SLL, T_SLA: step_out = out_q << step_s;
            T_SRL:        step_out = out_q >> step_s;
            T_SRA:        step_out = $signed(out_q) >>> step_s;
            T_ROL:        step_out = (out_q << step_s) | (out_q >> (WIDTH_W - step_s));
            T_ROR:        step_out = (out_q >> step_s) | (out_q << (WIDTH_W - step_s));
            default:      step_out = out_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        type_d  = type_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    out_d  = in_data;
                    type_d = shift_type;
                    rem_d  = shift_amnt;
                    // Reserved types (11x) pass straight through with no BUSY cycles
                    if ((shift_amnt != '0) && (shift_type[2:1] != 2'b11)) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                out_d = step_out;
                rem_d = rem_q - step_s[AW-1:0];
                if (rem_d == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            type_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            type_q  <= type_d;
        end
    end

    assign ready    = (state_q != S_BUSY);
    assign busy     = (state_q == S_BUSY);
    assign done     = (state_q == S_DONE);
    assign out_data = out_q;

`ifdef ITERATIVE_SHIFTER_FLAGS_EN
    localparam logic [WIDTH-1:0] BIT0  = 1;
    localparam logic [AW:0]      ONE_S = 1;

    logic carry_q, carry_d;
    logic zero_q, zero_d;
    logic step_carry;

    // Last bit leaving the register in this step; a zero-distance mask shifts out to 0
    always_comb begin
        step_carry = 1'b0;
        case (type_q)
            T_SLL, T_SLA: step_carry = |(out_q & (BIT0 << (WIDTH_W - step_s)));
            T_SRL, T_SRA: step_carry = |(out_q & (BIT0 << (step_s - ONE_S)));
            T_ROL:        step_carry = step_out[0];
            T_ROR:        step_carry = step_out[WIDTH-1];
            default:      step_carry = 1'b0;
        endcase

        carry_d = carry_q;
        if (state_q == S_BUSY) begin
            carry_d = step_carry;
        end else if (start) begin
            carry_d = 1'b0;
        end
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry_out = carry_q;
    assign zero      = zero_q;
`else
    assign carry_out = 1'b0;
    assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter (WIDTH=32, STEP=4); flag checks follow
// ITERATIVE_SHIFTER_FLAGS_EN.
module tb_iterative_shifter;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  in_data;
    logic [2:0]        shift_type;
    logic [4:0]        shift_amnt;
    logic              ready;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  out_data;
    logic              carry_out;
    logic              zero;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    iterative_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_data    (in_data),
        .shift_type (shift_type),
        .shift_amnt (shift_amnt),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .out_data   (out_data),
        .carry_out  (carry_out),
        .zero       (zero)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: one start pulse, then wait (bounded) for done; latency counted from accept edge
    task automatic do_op(input logic [31:0] d, input logic [2:0] t, input logic [4:0] a,
                         output int lat, output int busy_n);
        @(negedge clk);
        in_data    = d;
        shift_type = t;
        shift_amnt = a;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        in_data    = '0;
        shift_type = '0;
        shift_amnt = '0;
        #3;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out got %h exp 0", out_data); end
        checks++; if (carry_out !== 1'b0 || zero !== 1'b0) begin
            errors++; $display("FAIL reset_flags got c=%b z=%b exp 0 0", carry_out, zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_shift_ops();
        logic [31:0] vin  [13] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_00F1,
                                   32'h8000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000,
                                   32'h1234_5678, 32'hF000_0000, 32'h0000_ABCD, 32'h0000_0001,
                                   32'h1234_5678};
        logic [2:0]  vtyp [13] = '{3'b000, 3'b011, 3'b010, 3'b101, 3'b100, 3'b000, 3'b110,
                                   3'b011, 3'b100, 3'b010, 3'b001, 3'b101, 3'b111};
        logic [4:0]  vamt [13] = '{5'd31, 5'd4, 5'd4, 5'd8, 5'd1, 5'd0, 5'd5,
                                   5'd31, 5'd12, 5'd30, 5'd7, 5'd31, 5'd0};
        int          vlat [13] = '{9, 2, 2, 3, 2, 1, 1, 9, 4, 9, 3, 9, 1};
        int lat;
        int bn;
        logic [31:0] exp;
        exp_q = {32'h8000_0000, 32'hF800_0000, 32'h0800_0000, 32'hF100_0000,
                 32'h0000_0003, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                 32'h4567_8123, 32'h0000_0003, 32'h0055_E680, 32'h0000_0002,
                 32'h1234_5678};
        for (int i = 0; i < 13; i++) begin
            do_op(vin[i], vtyp[i], vamt[i], lat, bn);
            exp = exp_q.pop_front();
            checks++; if (lat !== vlat[i]) begin
                errors++; $display("FAIL op%0d_latency got %0d exp %0d", i, lat, vlat[i]);
            end
            checks++; if (bn !== vlat[i] - 1) begin
                errors++; $display("FAIL op%0d_busy_cycles got %0d exp %0d", i, bn, vlat[i] - 1);
            end
            checks++; if (out_data !== exp) begin
                errors++; $display("FAIL op%0d_out got %h exp %h", i, out_data, exp);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        int bn;
        do_op(32'h0000_00F0, 3'b010, 5'd4, lat, bn);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_idle got r=%b d=%b b=%b exp 1 0 0", ready, done, busy);
        end
        checks++; if (out_data !== 32'h0000_000F) begin
            errors++; $display("FAIL hold_out got %h exp 0000000f", out_data);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_data = 32'hDEAD_BEEF; shift_type = 3'b110; shift_amnt = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL b2b_first got d=%b out=%h exp 1 deadbeef", done, out_data);
        end
        // Second start presented during the DONE cycle
        in_data = 32'h8000_0000; shift_type = 3'b011; shift_amnt = 5'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept got b=%b d=%b exp 1 0", busy, done);
        end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b1 || out_data !== 32'hF800_0000) begin
            errors++; $display("FAIL b2b_second got d=%b out=%h exp 1 f8000000", done, out_data);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        in_data = 32'h0000_0001; shift_type = 3'b000; shift_amnt = 5'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 2) begin
                checks++; if (ready !== 1'b0) begin
                    errors++; $display("FAIL ignore_ready got %b exp 0", ready);
                end
                in_data = 32'hFFFF_FFFF; shift_type = 3'b101; shift_amnt = 5'd3; start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        checks++; if (lat !== 6) begin errors++; $display("FAIL ignore_latency got %0d exp 6", lat); end
        checks++; if (out_data !== 32'h0010_0000) begin
            errors++; $display("FAIL ignore_out got %h exp 00100000", out_data);
        end
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ignore_after got r=%b b=%b d=%b exp 1 0 0", ready, busy, done);
        end
    endtask

    task automatic test_reset_mid_busy();
        int pulses;
        int lat;
        int bn;
        @(negedge clk);
        in_data = 32'h0000_0001; shift_type = 3'b000; shift_amnt = 5'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state got r=%b b=%b d=%b exp 1 0 0", ready, busy, done);
        end
        checks++; if (out_data !== 32'h0 || carry_out !== 1'b0 || zero !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out got %h c=%b z=%b exp 0 0 0", out_data, carry_out, zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d exp 0", pulses); end
        do_op(32'h0000_0001, 3'b000, 5'd1, lat, bn);
        checks++; if (out_data !== 32'h0000_0002 || lat !== 2) begin
            errors++; $display("FAIL rst_mid_recover got %h lat %0d exp 00000002 lat 2", out_data, lat);
        end
    endtask

`ifdef ITERATIVE_SHIFTER_FLAGS_EN
    task automatic test_flags();
        logic [31:0] fin  [9] = '{32'h3, 32'h1, 32'hDEAD_BEEF, 32'h0800_0000, 32'h8000_0001,
                                  32'h2, 32'h6, 32'h10, 32'h0};
        logic [2:0]  ftyp [9] = '{3'b010, 3'b010, 3'b110, 3'b000, 3'b100, 3'b101, 3'b010,
                                  3'b010, 3'b000};
        logic [4:0]  famt [9] = '{5'd1, 5'd1, 5'd4, 5'd5, 5'd1, 5'd1, 5'd2, 5'd5, 5'd0};
        logic [31:0] fout [9] = '{32'h1, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h3, 32'h1, 32'h1,
                                  32'h0, 32'h0};
        logic        fc   [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        fz   [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        int bn;
        for (int i = 0; i < 9; i++) begin
            do_op(fin[i], ftyp[i], famt[i], lat, bn);
            checks++; if (out_data !== fout[i] || carry_out !== fc[i] || zero !== fz[i]) begin
                errors++;
                $display("FAIL flags%0d got out=%h c=%b z=%b exp out=%h c=%b z=%b",
                         i, out_data, carry_out, zero, fout[i], fc[i], fz[i]);
            end
        end
    endtask
`else
    task automatic test_flags();
        int lat;
        int bn;
        do_op(32'h1, 3'b010, 5'd1, lat, bn);
        checks++; if (out_data !== 32'h0 || carry_out !== 1'b0 || zero !== 1'b0) begin
            errors++; $display("FAIL flags_tied got out=%h c=%b z=%b exp 0 0 0", out_data, carry_out, zero);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_shift_ops();
        test_hold();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_busy();
        test_flags();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Parametrised, multi-cycle successor to the combinational 32-bit shifter in the ALU path.
- Shifts or rotates a WIDTH-bit operand by up to WIDTH-1 positions, moving at most STEP bit positions per clock. This keeps the logic per cycle small for timing-critical builds.
- A start/busy/done handshake lets the control FSM stall the execute stage while a shift is in progress.
- Adds rotate modes, which the current shifter does not provide.

Parameters:
- WIDTH, 32, operand and result width. Must be a power of 2 and at least 8.
- STEP, 4, maximum shift distance per BUSY cycle. Must be a power of 2, from 1 to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a shift. Sampled only when ready=1.
- in_data  input  WIDTH  operand. Captured when a start is accepted.
- shift_type  input  3  operation select (encodings in Behaviour). Captured when a start is accepted.
- shift_amnt  input  $clog2(WIDTH)  shift distance. Captured when a start is accepted.
- ready  output  1  high in IDLE and DONE, when a new start can be accepted.
- busy  output  1  high in BUSY.
- done  output  1  one-cycle pulse marking out_data valid.
- out_data  output  WIDTH  result register. Holds its value until the next accepted start.
- carry_out  output  1  last bit shifted out. Optional; see Optional Feature.
- zero  output  1  high when out_data==0. Optional; see Optional Feature.

Behaviour:
- Reset: asynchronous on rst_n=0, which may occur at any time, including mid-BUSY. It forces the following, and any in-flight operation is discarded with no done pulse:
  - state=IDLE, ready=1, busy=0, done=0;
  - out_data=0, carry_out=0, zero=0;
  - internal remaining count=0, latched type=0.
- shift_type encodings:
  - 000 SLL: logical shift left.
  - 001 SLA: identical to SLL.
  - 010 SRL: logical shift right, zero fill.
  - 011 SRA: arithmetic shift right, replicates the MSB.
  - 100 ROL: rotate left.
  - 101 ROR: rotate right.
  - 110, 111: reserved. Treated as pass-through: result = in_data, zero BUSY cycles.
- States: IDLE, BUSY, DONE.
  - IDLE, start=1: latch in_data into out_data, latch the type, remaining=shift_amnt. Go to BUSY if remaining!=0 and the type is not reserved; otherwise go to DONE.
  - BUSY: each cycle, shift/rotate out_data by s=min(remaining,STEP), then remaining-=s. When remaining reaches 0, go to DONE. start is ignored in BUSY.
  - DONE: done=1 for exactly this cycle.
    - start=1: accepted exactly as in IDLE (back-to-back operation, no idle gap).
    - otherwise: go to IDLE. out_data is held.
- Latency: done is asserted ceil(shift_amnt/STEP)+1 cycles after the accepting clock edge.
  - shift_amnt=0: done is asserted in the cycle right after accept, with out_data=in_data.
- Width rules:
  - SRA fill uses the MSB of the original operand. It stays constant across steps.
  - The full shift_amnt range 0..WIDTH-1 is legal. No saturation or modulo is needed.
- ready = (state!=BUSY), busy = (state==BUSY), combinational from state.

Optional Feature:
- Macro: ITERATIVE_SHIFTER_FLAGS_EN.
- When defined:
  - zero = (out_data==0), registered and updated together with out_data.
  - carry_out for SLL/SLA/SRL/SRA = the last bit shifted out across all steps.
  - carry_out for ROL = out_data[0]; for ROR = out_data[WIDTH-1].
  - carry_out=0 when shift_amnt=0 or the type is reserved.
  - Flags are valid on done and held with out_data.
- When not defined: carry_out and zero are tied to 0, and no flag logic is built.

Test Plan (WIDTH=32, STEP=4):
- SLL, in=0x0000_0001, amnt=31 -> busy for 8 cycles; done 9 cycles after accept; out=0x8000_0000.
- SRA, in=0x8000_0000, amnt=4 -> 1 BUSY cycle; done at +2; out=0xF800_0000. Same operand with SRL -> out=0x0800_0000.
- ROR, in=0x0000_00F1, amnt=8 -> out=0xF100_0000 at +3. ROL, in=0x8000_0001, amnt=1 -> out=0x0000_0003 at +2.
- amnt=0 or type=110, in=0xDEAD_BEEF -> done at +1, out=0xDEAD_BEEF. A start asserted in the DONE cycle is accepted immediately.
- SLL, amnt=20: pulse start again mid-BUSY -> ignored, result unaffected. A separate run with rst_n=0 at BUSY cycle 3 -> state IDLE, out=0, no done pulse.
- With the flags macro defined:
  - SRL, in=0x3, amnt=1 -> out=0x1, carry_out=1, zero=0.
  - SRL, in=0x1, amnt=1 -> out=0, carry_out=1, zero=1.
